fire_dispatch_par: RTL
======================

Name: fire_dispatch_par

Overview:
Parametrised successor to the single-lane fire dispatcher. It accepts synapse index ranges [syn_start, syn_end] from the axon stage through a small input FIFO. Each range is split into per-channel sub-ranges, and all synapse channels it touches are driven concurrently, so several synapse units work in parallel instead of one at a time. It sits between the axon unit and NUM_CH synapse units. It adds a busy/done indication and a malformed-range error pulse.

Parameters:
NUM_CH, 4, number of synapse channels (power of two, >=2)
ADDR_W, 10, per-channel synapse address width
IDX_W, ADDR_W+$clog2(NUM_CH), global synapse index width (derived, not overridden)
FIFO_DEPTH, 4, range FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
enable  in  1  global run enable; 0 freezes all state
step_done  out  1  1 when FIFO empty, no active range, no syn_vld pending
range_err  out  1  one-cycle pulse: range with start>end accepted and dropped
syn_start  in  IDX_W  first global synapse index of range
syn_end  in  IDX_W  last global synapse index (inclusive)
syn_in_vld  in  1  range valid
syn_in_rdy  out  1  range accepted when syn_in_vld&&syn_in_rdy
syn_vld  out  NUM_CH  per-channel address valid
syn_addr  out  NUM_CH*ADDR_W  per-channel local address, channel c at [c*ADDR_W +: ADDR_W]
syn_rdy  in  NUM_CH  per-channel ready

Behaviour:
- Index mapping: channel = idx[IDX_W-1:ADDR_W]; local addr = idx[ADDR_W-1:0].
- syn_in_rdy = enable && !fifo_full (combinational). Push on syn_in_vld&&syn_in_rdy. Simultaneous push and pop on a full FIFO is not allowed: rdy stays low while full.
- Range with syn_start>syn_end: never written to the FIFO. range_err=1 the next cycle. No other effect.
- States: IDLE, LOAD, RUN.
  - IDLE: if FIFO non-empty, pop the head and go to LOAD.
  - LOAD (1 cycle): for each c compute lo_c=max(start, c<<ADDR_W) and hi_c=min(end, (c<<ADDR_W)|{ADDR_W{1}}). Set cur_c=lo_c. Set active_c=(lo_c<=hi_c). Set syn_vld[c]=active_c (registered). Go to RUN.
  - RUN: each channel advances independently.
    - On syn_vld[c]&&syn_rdy[c]: if cur_c==hi_c, clear syn_vld[c] and active_c; else cur_c+=1 with syn_vld[c] held at 1.
    - When all active_c are clear (including clears in this cycle): if FIFO non-empty, pop and go to LOAD; else go to IDLE.
- Latency: a range accepted at cycle N into an empty idle block is popped at N+1, LOAD runs at N+2, and the first syn_vld is high at N+3. Back-to-back ranges cost 1 LOAD bubble per range.
- Handshake: while syn_vld[c]=1 and not accepted, syn_addr[c] is stable. A channel never drops vld without a transfer, except on reset. syn_addr for an inactive channel holds its last value and is don't-care.
- One transfer per channel per cycle. Up to NUM_CH transfers per cycle total.
- enable=0: syn_vld outputs forced to 0 combinationally, no transfers counted, FIFO/cursors/state frozen, syn_in_rdy=0. Resuming enable continues exactly where it stopped.
- step_done registered: 1 iff state==IDLE, FIFO empty, and no push this cycle.
- Reset (any state, mid-range included): FIFO emptied, state IDLE, syn_vld=0, syn_addr=0, cur/hi/active cleared, range_err=0, step_done=1. Reset has priority over enable and all handshakes.
- Range covering the full index space (0 to 2^IDX_W-1): no cursor overflow; the stop is on the equality compare only.
- Single-index range (start==end): exactly 1 transfer on 1 channel.

Test Plan:
- Single range start=0x005, end=0x007, all rdy=1 -> syn_vld[0] for 3 cycles, addr 5,6,7; first vld 3 cycles after accept; step_done returns 1.
- Spanning range start=0x3FE, end=0xC01 (NUM_CH=4) -> ch0 addrs 0x3FE,0x3FF; ch1 0x000..0x3FF; ch2 0x000..0x3FF; ch3 0x000,0x001. All channels start in the same cycle; total 2052 transfers.
- Backpressure: range 0x400..0x403, syn_rdy[1] toggling 1,0,0,1,... -> addr held stable while rdy=0; exactly 4 transfers, in order.
- FIFO full: push 5 ranges while ch0 rdy=0 -> syn_in_rdy low after 4 are buffered (1 active + 4 queued per depth). All ranges are later dispatched in order with 1-cycle LOAD gaps.
- Bad range start=0x010, end=0x00F -> range_err pulse 1 cycle, no syn_vld, step_done stays 1.
- Reset mid-run during range 0x000..0x0FF after 10 transfers -> next cycle all syn_vld=0, step_done=1. A subsequent range dispatches from its own start.

Source files
------------

// File: rtl/fire_dispatch_par_if.sv
// Range-input and per-channel synapse address handshakes of the parallel fire dispatcher.
interface fire_dispatch_par_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 10
);
  localparam int IDX_W = ADDR_W + $clog2(NUM_CH);

  logic [IDX_W-1:0]         syn_start;
  logic [IDX_W-1:0]         syn_end;
  logic                     syn_in_vld;
  logic                     syn_in_rdy;
  logic [NUM_CH-1:0]        syn_vld;
  logic [NUM_CH*ADDR_W-1:0] syn_addr;
  logic [NUM_CH-1:0]        syn_rdy;

  modport master (
    output syn_start, syn_end, syn_in_vld, syn_rdy,
    input  syn_in_rdy, syn_vld, syn_addr
  );

  modport slave (
    input  syn_start, syn_end, syn_in_vld, syn_rdy,
    output syn_in_rdy, syn_vld, syn_addr
  );
endinterface

// File: rtl/fire_dispatch_par.sv
// Parallel fire dispatcher: buffers synapse index ranges and walks every channel a range
// touches concurrently, one local address per channel per cycle.
module fire_dispatch_par #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               step_done,
  output logic               range_err,
  fire_dispatch_par_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int IDX_W = ADDR_W + CH_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              fifo_start_q [FIFO_DEPTH];
  logic [IDX_W-1:0]              fifo_start_d [FIFO_DEPTH];
  logic [IDX_W-1:0]              fifo_end_q   [FIFO_DEPTH];
  logic [IDX_W-1:0]              fifo_end_d   [FIFO_DEPTH];
  logic [PTR_W:0]                wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]                rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]              rng_start_q, rng_start_d;
  logic [IDX_W-1:0]              rng_end_q, rng_end_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] cur_q, cur_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] hi_q, hi_d;
  logic [NUM_CH-1:0]             active_q, active_d;
  logic                          range_err_q, range_err_d;
  logic                          step_done_q, step_done_d;

  logic             fifo_empty, fifo_full;
  logic             in_rdy, accept, bad_range, push, pop;
  logic [IDX_W-1:0] ch_base, ch_top, ch_lo, ch_hi;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign in_rdy    = enable && !fifo_full;
  assign accept    = in_rdy && bus.syn_in_vld;
  assign bad_range = (bus.syn_start > bus.syn_end);
  assign push      = accept && !bad_range;

  assign bus.syn_in_rdy = in_rdy;
  assign bus.syn_vld    = active_q & {NUM_CH{enable}};
  assign bus.syn_addr   = cur_q;
  assign step_done      = step_done_q;
  assign range_err      = range_err_q;

  always_comb begin
    state_d      = state_q;
    fifo_start_d = fifo_start_q;
    fifo_end_d   = fifo_end_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rng_start_d  = rng_start_q;
    rng_end_d    = rng_end_q;
    cur_d        = cur_q;
    hi_d         = hi_q;
    active_d     = active_q;
    pop          = 1'b0;
    ch_base      = '0;
    ch_top       = '0;
    ch_lo        = '0;
    ch_hi        = '0;
    range_err_d  = accept && bad_range;
    step_done_d  = (state_q == IDLE) && fifo_empty && !push;

    if (enable) begin
      if (push) begin
        fifo_start_d[wr_ptr_q[PTR_W-1:0]] = bus.syn_start;
        fifo_end_d[wr_ptr_q[PTR_W-1:0]]   = bus.syn_end;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty) pop = 1'b1;
        end
        LOAD: begin
          // Clip the range to each channel's window; untouched channels keep their old address.
          for (int c = 0; c < NUM_CH; c++) begin
            ch_base = IDX_W'(c) << ADDR_W;
            ch_top  = ch_base | IDX_W'((1 << ADDR_W) - 1);
            ch_lo   = (rng_start_q > ch_base) ? rng_start_q : ch_base;
            ch_hi   = (rng_end_q < ch_top) ? rng_end_q : ch_top;
            active_d[c] = (ch_lo <= ch_hi);
            if (ch_lo <= ch_hi) begin
              cur_d[c] = ch_lo[ADDR_W-1:0];
              hi_d[c]  = ch_hi[ADDR_W-1:0];
            end
          end
          state_d = RUN;
        end
        RUN: begin
          // Equality stop keeps the top-of-space index from ever needing a cursor wrap.
          for (int c = 0; c < NUM_CH; c++) begin
            if (active_q[c] && bus.syn_rdy[c]) begin
              if (cur_q[c] == hi_q[c]) active_d[c] = 1'b0;
              else                     cur_d[c]    = cur_q[c] + ADDR_W'(1);
            end
          end
          if (active_d == '0) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (pop) begin
        rng_start_d = fifo_start_q[rd_ptr_q[PTR_W-1:0]];
        rng_end_d   = fifo_end_q[rd_ptr_q[PTR_W-1:0]];
        rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(1);
        state_d     = LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rng_start_q <= '0;
      rng_end_q   <= '0;
      cur_q       <= '0;
      hi_q        <= '0;
      active_q    <= '0;
      range_err_q <= 1'b0;
      step_done_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_start_q[i] <= '0;
        fifo_end_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rng_start_q  <= rng_start_d;
      rng_end_q    <= rng_end_d;
      cur_q        <= cur_d;
      hi_q         <= hi_d;
      active_q     <= active_d;
      range_err_q  <= range_err_d;
      step_done_q  <= step_done_d;
      fifo_start_q <= fifo_start_d;
      fifo_end_q   <= fifo_end_d;
    end
  end
endmodule
